// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared bus width, FSM state encoding and requester IDs
// for the two-port RAM arbiter.
`default_nettype none

package ram_arbiter_pkg;

    localparam int WORD_BUS = 64;

    // Requester IDs double as bit positions in the one-hot grant vector.
    localparam logic ID_IF  = 1'b0;
    localparam logic ID_MEM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: one-hot grant between the IF and MEM requesters.
// ptr=0 favours MEM on contention, ptr=1 favours IF.
`default_nettype none

module ram_arb_pick
    import ram_arbiter_pkg::*;
(
    input  logic       if_valid,
    input  logic       mem_valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant         = '0;
        grant[ID_MEM] = mem_valid && (!if_valid || !ptr);
        grant[ID_IF]  = if_valid && (!mem_valid || ptr);
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ram_arbiter: IDLE/ACCESS/RESP arbiter sharing one RAM between IF and MEM.
// Define RAM_ARB_ROUND_ROBIN_EN for alternating grants; default is MEM priority.
`default_nettype none

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_W = WORD_BUS
) (
    input  logic              cpu_clk_50M,
    input  logic              rst,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [DATA_W-1:0] if_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [DATA_W-1:0] if_rsp_data,

    input  logic              mem_req_valid,
    output logic              mem_req_ready,
    input  logic              mem_req_we,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_wmask,
    output logic              mem_rsp_valid,
    input  logic              mem_rsp_ready,
    output logic [DATA_W-1:0] mem_rsp_data,

    output logic              ram_rd_en,
    output logic              ram_wr_en,
    output logic [DATA_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic [DATA_W-1:0] ram_wmask,
    input  logic [DATA_W-1:0] ram_rd_data
);

    state_t            state;
    logic              id_q;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wmask_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic [1:0] grant;
    logic       pick_ptr;
    logic       idle_open;
    logic       in_access;
    logic       in_resp;
    logic       rsp_fire;

    // Every strobe is gated by !rst so an abort in ACCESS never commits a write.
    assign idle_open = (state == ST_IDLE) && !rst;
    assign in_access = (state == ST_ACCESS) && !rst;
    assign in_resp   = (state == ST_RESP) && !rst;

    ram_arb_pick u_pick (
        .if_valid  (if_req_valid),
        .mem_valid (mem_req_valid),
        .ptr       (pick_ptr),
        .grant     (grant)
    );

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic rr_ptr;

    always_ff @(posedge cpu_clk_50M) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (idle_open && if_req_valid && mem_req_valid) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    assign pick_ptr = rr_ptr;
`else
    assign pick_ptr = 1'b0;
`endif

    assign if_req_ready  = idle_open && grant[ID_IF];
    assign mem_req_ready = idle_open && grant[ID_MEM];

    assign if_rsp_valid  = in_resp && (id_q == ID_IF);
    assign mem_rsp_valid = in_resp && (id_q == ID_MEM);
    assign if_rsp_data   = rsp_data_q;
    assign mem_rsp_data  = rsp_data_q;
    assign rsp_fire      = (if_rsp_valid && if_rsp_ready) || (mem_rsp_valid && mem_rsp_ready);

    assign ram_rd_en   = in_access && !we_q;
    assign ram_wr_en   = in_access && we_q;
    assign ram_wmask   = (in_access && we_q) ? wmask_q : '0;
    assign ram_addr    = addr_q;
    assign ram_wr_data = wdata_q;

    always_ff @(posedge cpu_clk_50M) begin
        if (rst) begin
            state      <= ST_IDLE;
            id_q       <= ID_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_req_valid || mem_req_valid) begin
                        state <= ST_ACCESS;
                        if (grant[ID_MEM]) begin
                            id_q    <= ID_MEM;
                            we_q    <= mem_req_we;
                            addr_q  <= mem_addr;
                            wdata_q <= mem_wdata;
                            wmask_q <= mem_wmask;
                        end else begin
                            // IF fetches are reads; write data is left as it was.
                            id_q    <= ID_IF;
                            we_q    <= 1'b0;
                            addr_q  <= if_addr;
                            wmask_q <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    rsp_data_q <= we_q ? '0 : ram_rd_data;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_fire) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: queue-driven requesters, RAM model and scoreboard monitor
// for ram_arbiter.
`default_nettype none

module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int DW = 64;

    typedef struct packed {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] wmask;
    } mreq_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
    logic [DW-1:0] if_addr, if_rsp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid, mem_rsp_ready;
    logic [DW-1:0] mem_addr, mem_wdata, mem_wmask, mem_rsp_data;
    logic          ram_rd_en, ram_wr_en;
    logic [DW-1:0] ram_addr, ram_wr_data, ram_wmask, ram_rd_data;

    logic [DW-1:0] ram [0:7];
    logic [DW-1:0] if_q[$];
    mreq_t         mem_q[$];
    logic [DW-1:0] exp_if[$];
    logic [DW-1:0] exp_mem[$];
    logic          exp_order[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int if_fire_cyc = 0;
    int if_lat = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int mask_err = 0;
    logic if_fire, mem_fire;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_W(DW)) dut (
        .cpu_clk_50M   (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_ready  (if_rsp_ready),
        .if_rsp_data   (if_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_data  (mem_rsp_data),
        .ram_rd_en     (ram_rd_en),
        .ram_wr_en     (ram_wr_en),
        .ram_addr      (ram_addr),
        .ram_wr_data   (ram_wr_data),
        .ram_wmask     (ram_wmask),
        .ram_rd_data   (ram_rd_data)
    );

    // Eight 64-bit words, selected by address bits [5:3].
    assign ram_rd_data = ram[ram_addr[5:3]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_wr_en)
            ram[ram_addr[5:3]] <= (ram[ram_addr[5:3]] & ~ram_wmask) | (ram_wr_data & ram_wmask);
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] m);
        mreq_t r;
        r.we = we; r.addr = a; r.wdata = d; r.wmask = m;
        mem_q.push_back(r);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((if_q.size() + mem_q.size() + exp_if.size() + exp_mem.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, (n >= 200) ? 1 : 0, 0);
        repeat (2) @(negedge clk);
    endtask

    // IF requester: presents the head of if_q, pops it after the handshake edge.
    initial begin
        if_req_valid = 1'b0;
        if_addr      = '0;
        forever begin
            @(negedge clk);
            if_fire = if_req_valid && if_req_ready;
            if (if_fire) if_fire_cyc = cyc;
            @(posedge clk);
            #1;
            if (if_fire) void'(if_q.pop_front());
            if (if_q.size() > 0) begin
                if_req_valid = 1'b1;
                if_addr      = if_q[0];
            end else begin
                if_req_valid = 1'b0;
            end
        end
    end

    initial begin
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wmask     = '0;
        forever begin
            @(negedge clk);
            mem_fire = mem_req_valid && mem_req_ready;
            @(posedge clk);
            #1;
            if (mem_fire) void'(mem_q.pop_front());
            if (mem_q.size() > 0) begin
                mem_req_valid = 1'b1;
                mem_req_we    = mem_q[0].we;
                mem_addr      = mem_q[0].addr;
                mem_wdata     = mem_q[0].wdata;
                mem_wmask     = mem_q[0].wmask;
            end else begin
                mem_req_valid = 1'b0;
            end
        end
    end

    // Scoreboard monitor: pops expectations on every response handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!ram_rd_en && !ram_wr_en && ram_wmask != '0) mask_err++;
            if (ram_rd_en) rd_cnt++;
            if (ram_wr_en) wr_cnt++;
            if (if_rsp_valid && if_rsp_ready) begin
                if (exp_if.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL if_rsp_unexpected: got 0x%0h expected no response", if_rsp_data);
                end else begin
                    check("if_rsp_data", if_rsp_data, exp_if.pop_front());
                    if_lat = cyc - if_fire_cyc;
                    if (exp_order.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL grant_order: got IF expected none");
                    end else check("grant_order_if", ID_IF, exp_order.pop_front());
                end
            end
            if (mem_rsp_valid && mem_rsp_ready) begin
                if (exp_mem.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL mem_rsp_unexpected: got 0x%0h expected no response", mem_rsp_data);
                end else begin
                    check("mem_rsp_data", mem_rsp_data, exp_mem.pop_front());
                    if (exp_order.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL grant_order: got MEM expected none");
                    end else check("grant_order_mem", ID_MEM, exp_order.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd0, wr0, n;
        rst           = 1'b1;
        if_rsp_ready  = 1'b1;
        mem_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) ram[i] = '0;
        ram[0] = 64'h1111_2222_3333_4444;
        ram[1] = 64'hAAAA_BBBB_CCCC_DDDD;
        ram[2] = 64'h0000_0000_DEAD_BEEF;
        ram[4] = 64'h0123_4567_89AB_CDEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_if_req_ready", if_req_ready, 0);
        check("rst_mem_req_ready", mem_req_ready, 0);
        check("rst_if_rsp_valid", if_rsp_valid, 0);
        check("rst_mem_rsp_valid", mem_rsp_valid, 0);
        check("rst_ram_en", {ram_rd_en, ram_wr_en}, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_rsp_data", if_rsp_data | mem_rsp_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Lone IF read: 2-cycle latency, one read strobe.
        @(negedge clk);
        rd0 = rd_cnt; wr0 = wr_cnt;
        if_q.push_back(64'h8000_0010);
        exp_if.push_back(64'h0000_0000_DEAD_BEEF);
        exp_order.push_back(ID_IF);
        wait_drain("t1_drain");
        check("t1_latency", if_lat, 2);
        check("t1_rd_en_cycles", rd_cnt - rd0, 1);
        check("t1_wr_en_cycles", wr_cnt - wr0, 0);
        check("t1_addr_hold", ram_addr, 64'h8000_0010);

        // Masked MEM write then read-back of the merged word.
        @(negedge clk);
        wr0 = wr_cnt;
        push_mem(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'h0000_0000_FFFF_FFFF);
        push_mem(1'b0, 64'h8000_0008, '0, '0);
        exp_mem.push_back(64'h0);
        exp_mem.push_back(64'hAAAA_BBBB_5566_7788);
        exp_order.push_back(ID_MEM);
        exp_order.push_back(ID_MEM);
        wait_drain("t2_drain");
        check("t2_ram_word", ram[1], 64'hAAAA_BBBB_5566_7788);
        check("t2_wr_en_cycles", wr_cnt - wr0, 1);

        // Contention: both requesters hold two reads each.
        @(negedge clk);
        if_q.push_back(64'h8000_0010);
        if_q.push_back(64'h8000_0020);
        exp_if.push_back(64'h0000_0000_DEAD_BEEF);
        exp_if.push_back(64'h0123_4567_89AB_CDEF);
        push_mem(1'b0, 64'h8000_0008, '0, '0);
        push_mem(1'b0, 64'h8000_0000, '0, '0);
        exp_mem.push_back(64'hAAAA_BBBB_5566_7788);
        exp_mem.push_back(64'h1111_2222_3333_4444);
`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_order.push_back(ID_MEM);
        exp_order.push_back(ID_IF);
        exp_order.push_back(ID_MEM);
        exp_order.push_back(ID_IF);
`else
        exp_order.push_back(ID_MEM);
        exp_order.push_back(ID_MEM);
        exp_order.push_back(ID_IF);
        exp_order.push_back(ID_IF);
`endif
        wait_drain("t3_drain");

        // Response back-pressure: MEM response held, IF waits.
        @(posedge clk);
        #1 mem_rsp_ready = 1'b0;
        @(negedge clk);
        push_mem(1'b0, 64'h8000_0010, '0, '0);
        exp_mem.push_back(64'h0000_0000_DEAD_BEEF);
        exp_order.push_back(ID_MEM);
        exp_order.push_back(ID_IF);
        n = 0;
        while (!mem_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_rsp_seen", mem_rsp_valid, 1);
        if_q.push_back(64'h8000_0020);
        exp_if.push_back(64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", mem_rsp_valid, 1);
            check("t4_hold_data", mem_rsp_data, 64'h0000_0000_DEAD_BEEF);
            check("t4_if_ready_low", if_req_ready, 0);
        end
        @(posedge clk);
        #1 mem_rsp_ready = 1'b1;
        wait_drain("t4_drain");

        // Reset during ACCESS of a write aborts it.
        @(negedge clk);
        push_mem(1'b1, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        n = 0;
        while (!mem_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_accepted", mem_req_ready, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t5_rst_wr_en", ram_wr_en, 0);
        check("t5_rst_rsp_valid", mem_rsp_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_ram_unchanged", ram[4], 64'h0123_4567_89AB_CDEF);
        check("t5_no_rsp", mem_rsp_valid, 0);
        if_q.push_back(64'h8000_0020);
        exp_if.push_back(64'h0123_4567_89AB_CDEF);
        exp_order.push_back(ID_IF);
        @(posedge clk);
        #2;
        @(negedge clk);
        check("t5_idle_ready", if_req_ready, 1);
        wait_drain("t5_drain");
        check("t5_ram_final", ram[4], 64'h0123_4567_89AB_CDEF);

        check("idle_mask_zero", mask_err, 0);
        check("order_queue_empty", exp_order.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
